regfile_bist: RTL and testbench

Built-in self-test controller that drives the write port and both read ports of the 8-entry register file (`regfiles`) as its initiator. On a start pulse it fills every entry with an address-derived pattern, reads it back on both read ports and compares. It reports pass/fail, the first failing address and the mismatch count. It sits beside the register file and owns its `we/wa/wd/ra1/ra2` inputs while busy.

---
 rtl/regfile_bist.sv | 150 +++++++++++++++
 tb/tb_regfile_bist.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_bist.sv
// regfile_bist: self-test controller for the 8-entry register file.
// Writes an address-derived pattern to every entry, reads it back on both
// read ports (ra1 ascending, ra2 descending), and reports pass/fail, the
// first failing address and the total mismatch count.
// Optional macro REGFILE_BIST_INV_EN adds a second pass with the inverted
// pattern; without it only the normal pass runs.
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | waiting for start; results held
// S_WRITE | writing pat(a) to entry a, one entry per cycle
// S_READ  | comparing rd1/rd2 against pat(ra1)/pat(ra2)
// S_DONE  | one-cycle done pulse, pass valid
module regfile_bist #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int DW    = 8
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW-1:0] err_addr,
  output logic [AW+2:0] err_cnt,
  output logic          we,
  output logic [AW-1:0] wa,
  output logic [DW-1:0] wd,
  output logic [AW-1:0] ra1,
  output logic [AW-1:0] ra2,
  input  logic [DW-1:0] rd1,
  input  logic [DW-1:0] rd2
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

  state_t        state;
  logic [AW-1:0] a;
  logic          inv;

  logic [AW-1:0] a_nxt;
  logic          last;
  logic          mis1;
  logic          mis2;
  logic [AW+2:0] cnt_nxt;

  // zero-extended address, optionally inverted
  function automatic logic [DW-1:0] pat(input logic [AW-1:0] x, input logic i);
    logic [DW-1:0] z;
    z = '0;
    z[AW-1:0] = x;
    return z ^ {DW{i}};
  endfunction

  // address step, last-entry detect and read-back comparison
  always_comb begin
    a_nxt   = a + 1'b1;
    last    = (a == AW'(DEPTH - 1));
    mis1    = (rd1 != pat(ra1, inv));
    mis2    = (rd2 != pat(ra2, inv));
    cnt_nxt = err_cnt + (AW+3)'(mis1) + (AW+3)'(mis2);
  end

  // sequencer with registered regfile drive and result outputs
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state    <= S_IDLE;
      a        <= '0;
      inv      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_addr <= '0;
      err_cnt  <= '0;
      we       <= 1'b0;
      wa       <= '0;
      wd       <= '0;
      ra1      <= '0;
      ra2      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_WRITE;
            busy     <= 1'b1;
            a        <= '0;
            inv      <= 1'b0;
            err_cnt  <= '0;
            err_addr <= '0;
            pass     <= 1'b0;
            we       <= 1'b1;
            wa       <= '0;
            wd       <= pat('0, 1'b0);
          end
        end
        S_WRITE: begin
          if (last) begin
            state <= S_READ;
            a     <= '0;
            we    <= 1'b0;
            ra1   <= '0;
            ra2   <= AW'(DEPTH - 1);
          end else begin
            a  <= a_nxt;
            wa <= a_nxt;
            wd <= pat(a_nxt, inv);
          end
        end
        S_READ: begin
          err_cnt <= cnt_nxt;
          // err_cnt still zero means this is the first mismatch of the run
          if (err_cnt == '0 && (mis1 || mis2))
            err_addr <= mis1 ? ra1 : ra2;
          if (last) begin
`ifdef REGFILE_BIST_INV_EN
            if (!inv) begin
              state <= S_WRITE;
              inv   <= 1'b1;
              a     <= '0;
              we    <= 1'b1;
              wa    <= '0;
              wd    <= pat('0, 1'b1);
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
              pass  <= (cnt_nxt == '0);
            end
`else
            state <= S_DONE;
            done  <= 1'b1;
            pass  <= (cnt_nxt == '0);
`endif
          end else begin
            a   <= a_nxt;
            ra1 <= a_nxt;
            ra2 <= ~a_nxt;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_bist.sv
// tb_regfile_bist: randomized and directed bench for regfile_bist with a
// cycle-level reference model driven by elapsed cycles since start.
module tb_regfile_bist;

  localparam int D = 8;
`ifdef REGFILE_BIST_INV_EN
  localparam int NP = 2;
`else
  localparam int NP = 1;
`endif
  localparam int L = 2 * D * NP;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, pass, we;
  logic [2:0] err_addr, wa, ra1, ra2;
  logic [5:0] err_cnt;
  logic [7:0] wd, rd1, rd2;

  logic [7:0] mem [D];
  logic [7:0] and1 = 8'hFF, or1 = 8'h00, and2 = 8'hFF, or2 = 8'h00;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  regfile_bist #(.DEPTH(8), .AW(3), .DW(8)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start),
    .busy(busy), .done(done), .pass(pass), .err_addr(err_addr), .err_cnt(err_cnt),
    .we(we), .wa(wa), .wd(wd), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2)
  );

  always #5 sys_clk = ~sys_clk;

  // register file with stuck-bit fault injection on each read port
  always @(posedge sys_clk) if (we) mem[wa] <= wd;
  assign rd1 = (mem[ra1] & and1) | or1;
  assign rd2 = (mem[ra2] & and2) | or2;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pat(input int x, input int p);
    return 8'(x) ^ ((p != 0) ? 8'hFF : 8'h00);
  endfunction

  // reference model: t counts cycles since the accepting edge (0 = idle)
  int t = 0;
  bit seen = 1'b0;
  int e_cnt = 0, e_addr = 0, e_pass = 0;
  int e_wa = 0, e_wd = 0, e_ra1 = 0, e_ra2 = 0;
  int e_we = 0, e_busy = 0, e_done = 0;

  always @(posedge sys_clk) begin
    int p, k, ax, bx;
    logic [7:0] x1, x2;
    bit m1, m2;
    if (!sys_rst_n) begin
      t = 0; seen = 0; e_cnt = 0; e_addr = 0; e_pass = 0;
      e_wa = 0; e_wd = 0; e_ra1 = 0; e_ra2 = 0;
    end else begin
      if (t >= 1 && t <= L) begin
        p = (t - 1) / (2 * D);
        k = (t - 1) % (2 * D);
        if (k >= D) begin
          ax = k - D;
          bx = D - 1 - ax;
          x1 = pat(ax, p);
          x2 = pat(bx, p);
          m1 = (((x1 & and1) | or1) != x1);
          m2 = (((x2 & and2) | or2) != x2);
          if (!seen && (m1 || m2)) begin
            e_addr = m1 ? ax : bx;
            seen = 1;
          end
          e_cnt += int'(m1) + int'(m2);
        end
      end
      if (t == 0) begin
        if (start) begin
          t = 1; e_cnt = 0; e_addr = 0; e_pass = 0; seen = 0;
        end
      end else if (t == L + 1) t = 0;
      else t = t + 1;
      if (t == L + 1) e_pass = (e_cnt == 0) ? 1 : 0;
      if (t >= 1 && t <= L) begin
        p = (t - 1) / (2 * D);
        k = (t - 1) % (2 * D);
        if (k < D) begin
          e_wa = k; e_wd = pat(k, p);
        end else begin
          e_ra1 = k - D; e_ra2 = D - 1 - (k - D);
        end
      end
    end
    e_busy = (t != 0) ? 1 : 0;
    e_done = (t == L + 1) ? 1 : 0;
    e_we   = (t >= 1 && t <= L && ((t - 1) % (2 * D)) < D) ? 1 : 0;
  end

  // compare every output against the model on the falling edge
  always @(negedge sys_clk) begin
    if (chk_en) begin
      chk("busy", int'(busy), e_busy);
      chk("done", int'(done), e_done);
      chk("pass", int'(pass), e_pass);
      chk("err_addr", int'(err_addr), e_addr);
      chk("err_cnt", int'(err_cnt), e_cnt);
      chk("we", int'(we), e_we);
      chk("wa", int'(wa), e_wa);
      chk("wd", int'(wd), e_wd);
      chk("ra1", int'(ra1), e_ra1);
      chk("ra2", int'(ra2), e_ra2);
    end
  end

  task automatic run_test(input logic [7:0] a1, o1, a2, o2, input bit again,
                          input int x_pass, x_cnt, x_addr);
    int lat;
    logic [7:0] wd0, wd5;
    logic [7:0] wdi;
    and1 = a1; or1 = o1; and2 = a2; or2 = o2;
    @(negedge sys_clk); start = 1'b1;
    @(negedge sys_clk); start = 1'b0;
    lat = 0; wd0 = 8'h55; wd5 = 8'h55; wdi = 8'h55;
    while (done !== 1'b1 && lat < 200) begin
      if (lat == 0) wd0 = wd;
      if (lat == 5) wd5 = wd;
      if (lat == 2 * D) wdi = wd;
      start = (again && lat == 3);
      @(negedge sys_clk);
      lat++;
    end
    start = 1'b0;
    if (lat >= 200) begin
      errors++;
      $display("FAIL done_timeout actual=none required=%0d cycles", L);
    end
    chk("latency", lat, L);
    chk("first_wd", int'(wd0), 0);
    chk("wd_at_5", int'(wd5), 5);
`ifdef REGFILE_BIST_INV_EN
    chk("inv_first_wd", int'(wdi), 8'hFF);
`endif
    chk("lit_pass", int'(pass), x_pass);
    chk("lit_err_cnt", int'(err_cnt), x_cnt);
    chk("lit_err_addr", int'(err_addr), x_addr);
    repeat (3) @(negedge sys_clk);
    chk("lit_pass_held", int'(pass), x_pass);
  endtask

  initial begin
    int n;
    for (int i = 0; i < D; i++) mem[i] = 8'h00;
    repeat (2) @(negedge sys_clk);
    chk_en = 1'b1;
    sys_rst_n = 1'b1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);

    // healthy regfile
    run_test(8'hFF, 8'h00, 8'hFF, 8'h00, 0, 1, 0, 0);
    // rd1 bit0 stuck at 0
    run_test(8'hFE, 8'h00, 8'hFF, 8'h00, 0, 0, 4 * NP, 1);
    // rd2 bit7 stuck at 1 (inverted pass has bit7 set, so no extra errors)
    run_test(8'hFF, 8'h00, 8'hFF, 8'h80, 0, 0, 8, 7);
    // second start during WRITE is ignored
    run_test(8'hFF, 8'h00, 8'hFF, 8'h00, 1, 1, 0, 0);
    n = 0;
    repeat (L + 4) begin
      @(negedge sys_clk);
      if (done) n++;
    end
    chk("no_extra_done", n, 0);

    // reset for one edge during READ
    @(negedge sys_clk); start = 1'b1;
    @(negedge sys_clk); start = 1'b0;
    repeat (D + 2) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    @(negedge sys_clk); sys_rst_n = 1'b1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_we", int'(we), 0);
    chk("mid_rst_ra1", int'(ra1), 0);
    run_test(8'hFF, 8'h00, 8'hFF, 8'h00, 0, 1, 0, 0);

    // held start re-arms every L+2 cycles
    @(negedge sys_clk); start = 1'b1;
    n = 0;
    repeat (2 * (L + 2)) begin
      @(negedge sys_clk);
      if (done) n++;
    end
    start = 1'b0;
    chk("held_done_count", n, 2);
    repeat (L + 4) @(negedge sys_clk);

    // randomized starts, fault masks and occasional resets
    repeat (1500) begin
      @(negedge sys_clk);
      start = ($urandom_range(0, 5) == 0);
      sys_rst_n = ($urandom_range(0, 249) != 0);
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 3))
          0: begin and1 = 8'hFF; or1 = 8'h00; and2 = 8'hFF; or2 = 8'h00; end
          1: begin and1 = ~(8'h01 << $urandom_range(0, 7)); or1 = 8'h00; end
          2: begin or2 = 8'h01 << $urandom_range(0, 7); and2 = 8'hFF; end
          default: begin and1 = 8'($urandom()) | 8'hF0; or2 = 8'($urandom()) & 8'h0F; end
        endcase
      end
    end
    start = 1'b0; sys_rst_n = 1'b1;
    and1 = 8'hFF; or1 = 8'h00; and2 = 8'hFF; or2 = 8'h00;
    repeat (L + 6) @(negedge sys_clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
